// File: rtl/mm_job_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// mm_job_sequencer_pkg
//
// Shared definitions for the mm job sequencer slice:
//   - ADDR_WIDTH : dimension/base-address width shared with the accelerator
//                  controller. Taken from the `ADDR_WIDTH macro when the build
//                  supplies one (normally from def.v), otherwise 16.
//   - seq_state_e: sequencer FSM state encoding (IDLE, ISSUE, WAIT, RELEASE).
//   - Job record layout used inside the job FIFO. Total width is 6*AW+IDW:
//       [IDW-1:0]                     job ID
//       [IDW + FLD_x*AW +: AW]        field x (M, K, N, BASE_A, BASE_B, BASE_P)
//
// Optional feature macro used elsewhere in the slice: MM_JOB_PERF_EN.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

package mm_job_sequencer_pkg;

    localparam int ADDR_WIDTH = `ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } seq_state_e;

    localparam int FLD_M         = 0;
    localparam int FLD_K         = 1;
    localparam int FLD_N         = 2;
    localparam int FLD_BASE_A    = 3;
    localparam int FLD_BASE_B    = 4;
    localparam int FLD_BASE_P    = 5;
    localparam int NUM_AW_FIELDS = 6;

    // Total width of one packed job record.
    function automatic int jobWidth(input int aw, input int idw);
        return NUM_AW_FIELDS * aw + idw;
    endfunction

    // Bit offset of an AW-wide field inside the packed job record.
    function automatic int fieldLsb(input int aw, input int idw, input int fld);
        return idw + fld * aw;
    endfunction

endpackage

// File: rtl/mm_job_fifo.sv
// ----------------------------------------------------------------------------
// mm_job_fifo
//
// Parameterised synchronous FIFO holding packed job records.
//
// Parameters:
//   WIDTH : record width in bits
//   DEPTH : number of entries (power of 2, >= 2)
//
// Ports:
//   clk_i   in   clock
//   rst_i   in   asynchronous active-high reset (empties the FIFO)
//   push_i  in   write data_i; ignored while full (even if popping)
//   data_i  in   record to write
//   pop_i   in   discard the head; ignored while empty
//   data_o  out  head record (valid while !empty_o)
//   full_o  out  count == DEPTH
//   empty_o out  count == 0
//   count_o out  number of stored records
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module mm_job_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q;
    logic [PW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic             doPush;
    logic             doPop;

    // Full/empty come straight from the registered count, so a push while
    // full is refused even when the same cycle also pops.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign data_o  = mem_q[rdPtr_q];

    // Storage array: plain registers with no reset, only written on a push.
    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of 2; the count only
    // moves when exactly one of push/pop takes effect.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mm_job_sequencer.sv
// ----------------------------------------------------------------------------
// mm_job_sequencer
//
// Host-side initiator for the mm accelerator start/valid handshake. Jobs
// (m, k, n, base A/B/P) are queued, tagged with a wrapping ID, and issued one
// at a time: start_o is held with stable parameters until valid_i rises, then
// dropped until valid_i falls. Jobs with a zero dimension are rejected without
// ever raising start_o. Each job ends with a one-cycle done_o pulse.
//
// Parameters: AW (dimension/address width), DEPTH (queue entries, power of 2),
//             IDW (job ID width, IDs wrap modulo 2^IDW)
//
// Ports:
//   clk_i, rst_i                     clock, async active-high reset
//   cmd_valid_i / cmd_ready_o        host push handshake
//   cmd_m_i .. cmd_base_p_i          job descriptor
//   cmd_id_o                         ID the next accepted push will receive
//   start_o / valid_i                controller handshake
//   m_o .. base_p_o                  job parameters to the controller
//   busy_o, pending_o                FSM not idle, queued job count
//   done_o, done_id_o, done_err_o    completion pulse, job ID, rejected flag
//   done_cycles_o                    WAIT+RELEASE cycle count (MM_JOB_PERF_EN)
//
// Optional feature macro: MM_JOB_PERF_EN adds done_cycles_o and its counter.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module mm_job_sequencer
    import mm_job_sequencer_pkg::*;
#(
    parameter int AW    = ADDR_WIDTH,
    parameter int DEPTH = 4,
    parameter int IDW   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cmd_valid_i,
    output logic                         cmd_ready_o,
    input  logic [AW-1:0]                cmd_m_i,
    input  logic [AW-1:0]                cmd_k_i,
    input  logic [AW-1:0]                cmd_n_i,
    input  logic [AW-1:0]                cmd_base_a_i,
    input  logic [AW-1:0]                cmd_base_b_i,
    input  logic [AW-1:0]                cmd_base_p_i,
    output logic [IDW-1:0]               cmd_id_o,
    output logic                         start_o,
    input  logic                         valid_i,
    output logic [AW-1:0]                m_o,
    output logic [AW-1:0]                k_o,
    output logic [AW-1:0]                n_o,
    output logic [AW-1:0]                base_a_o,
    output logic [AW-1:0]                base_b_o,
    output logic [AW-1:0]                base_p_o,
    output logic                         busy_o,
    output logic [$clog2(DEPTH+1)-1:0]   pending_o,
    output logic                         done_o,
    output logic [IDW-1:0]               done_id_o,
    output logic                         done_err_o
`ifdef MM_JOB_PERF_EN
    ,
    output logic [31:0]                  done_cycles_o
`endif
);

    localparam int JW     = jobWidth(AW, IDW);
    localparam int CW     = $clog2(DEPTH+1);
    localparam int LSB_M  = fieldLsb(AW, IDW, FLD_M);
    localparam int LSB_K  = fieldLsb(AW, IDW, FLD_K);
    localparam int LSB_N  = fieldLsb(AW, IDW, FLD_N);
    localparam int LSB_A  = fieldLsb(AW, IDW, FLD_BASE_A);
    localparam int LSB_B  = fieldLsb(AW, IDW, FLD_BASE_B);
    localparam int LSB_P  = fieldLsb(AW, IDW, FLD_BASE_P);

    seq_state_e     state_q;
    logic           start_q;
    logic           done_q;
    logic           doneErr_q;
    logic [IDW-1:0] doneId_q;
    logic [AW-1:0]  jobM_q;
    logic [AW-1:0]  jobK_q;
    logic [AW-1:0]  jobN_q;
    logic [AW-1:0]  jobA_q;
    logic [AW-1:0]  jobB_q;
    logic [AW-1:0]  jobP_q;
    logic [IDW-1:0] jobId_q;
    logic [IDW-1:0] idCount_q;
    logic [IDW-1:0] idCount_d;

    logic [JW-1:0]  pushRec;
    logic [JW-1:0]  headRec;
    logic           fifoFull;
    logic           fifoEmpty;
    logic [CW-1:0]  fifoCount;
    logic           pushAcc;
    logic           popReq;
    logic           jobZero;

    assign pushAcc     = cmd_valid_i & ~fifoFull;
    assign popReq      = (state_q == ST_IDLE) & ~fifoEmpty;
    assign jobZero     = (jobM_q == '0) | (jobK_q == '0) | (jobN_q == '0);

    assign cmd_ready_o = ~fifoFull;
    assign cmd_id_o    = idCount_q;
    assign pending_o   = fifoCount;
    assign busy_o      = (state_q != ST_IDLE);
    assign start_o     = start_q;
    assign done_o      = done_q;
    assign done_err_o  = doneErr_q;
    assign done_id_o   = doneId_q;
    assign m_o         = jobM_q;
    assign k_o         = jobK_q;
    assign n_o         = jobN_q;
    assign base_a_o    = jobA_q;
    assign base_b_o    = jobB_q;
    assign base_p_o    = jobP_q;

    // Pack the host descriptor together with the ID it is being assigned.
    always_comb begin
        pushRec                 = '0;
        pushRec[IDW-1:0]        = idCount_q;
        pushRec[LSB_M +: AW]    = cmd_m_i;
        pushRec[LSB_K +: AW]    = cmd_k_i;
        pushRec[LSB_N +: AW]    = cmd_n_i;
        pushRec[LSB_A +: AW]    = cmd_base_a_i;
        pushRec[LSB_B +: AW]    = cmd_base_b_i;
        pushRec[LSB_P +: AW]    = cmd_base_p_i;
    end

    mm_job_fifo #(
        .WIDTH (JW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pushAcc),
        .data_i  (pushRec),
        .pop_i   (popReq),
        .data_o  (headRec),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    // The ID counter only advances on an accepted push; the IDW-bit add
    // wraps modulo 2^IDW on its own.
    always_comb begin
        idCount_d = idCount_q;
        if (pushAcc) begin
            idCount_d = idCount_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idCount_q <= '0;
        end else begin
            idCount_q <= idCount_d;
        end
    end

    // Issue FSM. start_q is set on the ISSUE->WAIT transition and cleared on
    // WAIT->RELEASE so it is high exactly while in WAIT. Job registers load
    // only on a pop in IDLE, keeping them stable through RELEASE. valid_i is
    // not looked at in IDLE/ISSUE, so a stale handshake is ignored there.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            doneErr_q <= 1'b0;
            doneId_q  <= '0;
            jobM_q    <= '0;
            jobK_q    <= '0;
            jobN_q    <= '0;
            jobA_q    <= '0;
            jobB_q    <= '0;
            jobP_q    <= '0;
            jobId_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifoEmpty) begin
                        jobM_q  <= headRec[LSB_M +: AW];
                        jobK_q  <= headRec[LSB_K +: AW];
                        jobN_q  <= headRec[LSB_N +: AW];
                        jobA_q  <= headRec[LSB_A +: AW];
                        jobB_q  <= headRec[LSB_B +: AW];
                        jobP_q  <= headRec[LSB_P +: AW];
                        jobId_q <= headRec[IDW-1:0];
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (jobZero) begin
                        done_q    <= 1'b1;
                        doneErr_q <= 1'b1;
                        doneId_q  <= jobId_q;
                        state_q   <= ST_IDLE;
                    end else begin
                        start_q   <= 1'b1;
                        state_q   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (valid_i) begin
                        start_q <= 1'b0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!valid_i) begin
                        done_q    <= 1'b1;
                        doneErr_q <= 1'b0;
                        doneId_q  <= jobId_q;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    start_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MM_JOB_PERF_EN
    logic [31:0] perfCount_q;
    logic [31:0] perfNext;
    logic [31:0] doneCycles_q;

    assign perfNext      = (perfCount_q == 32'hFFFF_FFFF) ? perfCount_q : perfCount_q + 32'd1;
    assign done_cycles_o = doneCycles_q;

    // Cycle counter: cleared on entry to WAIT, saturating increment in WAIT
    // and RELEASE. The reported value includes the final RELEASE cycle, which
    // is why the done value is taken from perfNext rather than perfCount_q.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perfCount_q  <= '0;
            doneCycles_q <= '0;
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    perfCount_q <= '0;
                    if (jobZero) begin
                        doneCycles_q <= '0;
                    end
                end
                ST_WAIT: begin
                    perfCount_q <= perfNext;
                end
                ST_RELEASE: begin
                    perfCount_q <= perfNext;
                    if (!valid_i) begin
                        doneCycles_q <= perfNext;
                    end
                end
                default: begin
                    perfCount_q <= perfCount_q;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mm_job_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mm_job_sequencer
//
// Self-checking bench for mm_job_sequencer. Pushed jobs put their expected
// completion record into a scoreboard queue; a monitor pops and compares on
// every done_o pulse. A small controller model answers start_o with valid_i
// after a programmable delay. MM_JOB_PERF_EN also checks done_cycles_o.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mm_job_sequencer;
    import mm_job_sequencer_pkg::*;

    localparam int AW    = ADDR_WIDTH;
    localparam int DEPTH = 4;
    localparam int IDW   = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic           cmd_valid_i;
    logic           cmd_ready_o;
    logic [AW-1:0]  cmd_m_i, cmd_k_i, cmd_n_i;
    logic [AW-1:0]  cmd_base_a_i, cmd_base_b_i, cmd_base_p_i;
    logic [IDW-1:0] cmd_id_o;
    logic           start_o;
    logic           valid_i;
    logic [AW-1:0]  m_o, k_o, n_o, base_a_o, base_b_o, base_p_o;
    logic           busy_o;
    logic [CW-1:0]  pending_o;
    logic           done_o;
    logic [IDW-1:0] done_id_o;
    logic           done_err_o;
`ifdef MM_JOB_PERF_EN
    logic [31:0]    done_cycles_o;
`endif

    typedef struct {
        logic [AW-1:0]  m, k, n, a, b, p;
        logic [IDW-1:0] id;
        logic           err;
        logic [31:0]    cyc;
    } expJob_t;

    expJob_t expQ[$];
    int      checks    = 0;
    int      errors    = 0;
    int      idModel   = 0;
    int      vd        = 20;
    int      doneCount = 0;
    bit      startSeen = 1'b0;
    int      ctlCnt    = 0;
    bit      ctlHigh   = 1'b0;

    mm_job_sequencer #(
        .AW    (AW),
        .DEPTH (DEPTH),
        .IDW   (IDW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_m_i       (cmd_m_i),
        .cmd_k_i       (cmd_k_i),
        .cmd_n_i       (cmd_n_i),
        .cmd_base_a_i  (cmd_base_a_i),
        .cmd_base_b_i  (cmd_base_b_i),
        .cmd_base_p_i  (cmd_base_p_i),
        .cmd_id_o      (cmd_id_o),
        .start_o       (start_o),
        .valid_i       (valid_i),
        .m_o           (m_o),
        .k_o           (k_o),
        .n_o           (n_o),
        .base_a_o      (base_a_o),
        .base_b_o      (base_b_o),
        .base_p_o      (base_p_o),
        .busy_o        (busy_o),
        .pending_o     (pending_o),
        .done_o        (done_o),
        .done_id_o     (done_id_o),
        .done_err_o    (done_err_o)
`ifdef MM_JOB_PERF_EN
        ,
        .done_cycles_o (done_cycles_o)
`endif
    );

    // Free-running 10 ns clock.
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller model: counts start_o cycles, raises valid_i so that WAIT
    // lasts vd cycles, then drops valid_i as soon as start_o is seen low.
    always @(negedge clk_i) begin
        if (rst_i) begin
            valid_i = 1'b0;
            ctlCnt  = 0;
            ctlHigh = 1'b0;
        end else if (!ctlHigh) begin
            if (start_o) begin
                ctlCnt++;
                if (ctlCnt >= vd) begin
                    valid_i = 1'b1;
                    ctlHigh = 1'b1;
                    ctlCnt  = 0;
                end
            end
        end else begin
            checkOutput("start_drop_on_valid", 64'(start_o), 64'd0);
            valid_i = 1'b0;
            ctlHigh = 1'b0;
        end
    end

    // Monitor: every done_o pulse is matched against the scoreboard head,
    // including the job parameters still held on the controller outputs.
    always @(negedge clk_i) begin : monitor
        expJob_t e;
        if (!rst_i) begin
            if (start_o) startSeen = 1'b1;
            if (done_o) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done_id %0d, expected no completion", done_id_o);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done_id",  64'(done_id_o),  64'(e.id));
                    checkOutput("done_err", 64'(done_err_o), 64'(e.err));
                    checkOutput("held_m",   64'(m_o),        64'(e.m));
                    checkOutput("held_k",   64'(k_o),        64'(e.k));
                    checkOutput("held_n",   64'(n_o),        64'(e.n));
                    checkOutput("held_a",   64'(base_a_o),   64'(e.a));
                    checkOutput("held_b",   64'(base_b_o),   64'(e.b));
                    checkOutput("held_p",   64'(base_p_o),   64'(e.p));
                    if (e.err) checkOutput("no_start_on_reject", 64'(startSeen), 64'd0);
`ifdef MM_JOB_PERF_EN
                    checkOutput("done_cycles", 64'(done_cycles_o), 64'(e.cyc));
`endif
                end
                startSeen = 1'b0;
            end
        end
    end

    task automatic resetDut();
        @(negedge clk_i);
        rst_i       = 1'b1;
        cmd_valid_i = 1'b0;
        expQ.delete();
        idModel     = 0;
        doneCount   = 0;
        startSeen   = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Offer one job and block until it is accepted (bounded); the expected
    // completion is queued in push order.
    task automatic applyStimulus(input int m, input int k, input int n,
                                 input int a, input int b, input int p, input bit syncFirst);
        expJob_t e;
        int      tries;
        if (syncFirst) @(negedge clk_i);
        cmd_m_i      = AW'(m);
        cmd_k_i      = AW'(k);
        cmd_n_i      = AW'(n);
        cmd_base_a_i = AW'(a);
        cmd_base_b_i = AW'(b);
        cmd_base_p_i = AW'(p);
        cmd_valid_i  = 1'b1;
        e.m   = AW'(m);
        e.k   = AW'(k);
        e.n   = AW'(n);
        e.a   = AW'(a);
        e.b   = AW'(b);
        e.p   = AW'(p);
        e.id  = IDW'(idModel % (1 << IDW));
        e.err = (m == 0) || (k == 0) || (n == 0);
        e.cyc = e.err ? 32'd0 : 32'(vd + 1);
        expQ.push_back(e);
        tries = 0;
        while (!cmd_ready_o && tries < 500) begin
            @(negedge clk_i);
            tries++;
        end
        if (!cmd_ready_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: got cmd_ready_o=0, expected 1 within 500 cycles");
            cmd_valid_i = 1'b0;
            void'(expQ.pop_back());
            return;
        end
        @(posedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        idModel++;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy_o) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("drain_scoreboard", 64'(expQ.size()), 64'd0);
    endtask

    // Global time bound so the run always terminates.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got no completion of the run, expected $finish before time limit");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst_i        = 1'b1;
        cmd_valid_i  = 1'b0;
        valid_i      = 1'b0;
        cmd_m_i      = '0;
        cmd_k_i      = '0;
        cmd_n_i      = '0;
        cmd_base_a_i = '0;
        cmd_base_b_i = '0;
        cmd_base_p_i = '0;
        repeat (3) @(negedge clk_i);

        $display("[TB] reset state");
        checkOutput("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
        checkOutput("rst_pending",   64'(pending_o),   64'd0);
        checkOutput("rst_busy",      64'(busy_o),      64'd0);
        checkOutput("rst_start",     64'(start_o),     64'd0);
        checkOutput("rst_done",      64'(done_o),      64'd0);
        checkOutput("rst_done_id",   64'(done_id_o),   64'd0);
        checkOutput("rst_done_err",  64'(done_err_o),  64'd0);
        checkOutput("rst_cmd_id",    64'(cmd_id_o),    64'd0);
        checkOutput("rst_m",         64'(m_o),         64'd0);
        checkOutput("rst_base_p",    64'(base_p_o),    64'd0);
        rst_i = 1'b0;

        $display("[TB] single job and issue latency");
        vd = 20;
        applyStimulus(16, 8, 8, 'h0, 'h100, 'h200, 1'b1);
        @(negedge clk_i);
        checkOutput("lat_pending_t0", 64'(pending_o), 64'd1);
        checkOutput("lat_busy_t0",    64'(busy_o),    64'd0);
        @(negedge clk_i);
        checkOutput("lat_start_issue", 64'(start_o),   64'd0);
        checkOutput("lat_busy_issue",  64'(busy_o),    64'd1);
        checkOutput("lat_pending_pop", 64'(pending_o), 64'd0);
        @(negedge clk_i);
        checkOutput("lat_start_wait", 64'(start_o),  64'd1);
        checkOutput("lat_m_out",      64'(m_o),      64'd16);
        checkOutput("lat_base_b_out", 64'(base_b_o), 64'h100);
        waitIdle();

        $display("[TB] reject zero dimension");
        resetDut();
        applyStimulus(0, 4, 4, 'h10, 'h20, 'h30, 1'b1);
        applyStimulus(4, 4, 4, 'h40, 'h50, 'h60, 1'b1);
        waitIdle();
        checkOutput("cmd_id_after_reject", 64'(cmd_id_o), 64'd2);

        $display("[TB] queue full");
        resetDut();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(i + 1, 2, 3, i * 'h40, 'h1000 + i, 'h2000 + i, 1'b1);
        end
        @(negedge clk_i);
        checkOutput("full_cmd_ready", 64'(cmd_ready_o), 64'd0);
        checkOutput("full_pending",   64'(pending_o),   64'd4);
        checkOutput("full_start",     64'(start_o),     64'd1);
        checkOutput("full_cmd_id",    64'(cmd_id_o),    64'd5);
        applyStimulus(6, 2, 3, 'h300, 'h1005, 'h2005, 1'b0);
        checkOutput("sixth_after_first_done", 64'(doneCount), 64'd1);
        @(negedge clk_i);
        checkOutput("full_pending_refill", 64'(pending_o), 64'd4);
        waitIdle();

        $display("[TB] simultaneous push and pop");
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2, 2, 2, i, i + 1, i + 2, 1'b1);
        end
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(done_o && pending_o == CW'(2)) && n < 500);
        checkOutput("pushpop_setup_found", 64'(n < 500), 64'd1);
        applyStimulus(3, 3, 3, 'h7, 'h8, 'h9, 1'b0);
        @(negedge clk_i);
        checkOutput("pushpop_pending", 64'(pending_o), 64'd2);
        checkOutput("pushpop_cmd_id",  64'(cmd_id_o),  64'd4);
        waitIdle();

        $display("[TB] reset during WAIT");
        applyStimulus(5, 5, 5, 'h11, 'h22, 'h33, 1'b1);
        n = 0;
        while (!start_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("midwait_start_before", 64'(start_o), 64'd1);
        rst_i = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midwait_start",   64'(start_o),     64'd0);
        checkOutput("midwait_pending", 64'(pending_o),   64'd0);
        checkOutput("midwait_busy",    64'(busy_o),      64'd0);
        checkOutput("midwait_cmd_id",  64'(cmd_id_o),    64'd0);
        checkOutput("midwait_ready",   64'(cmd_ready_o), 64'd1);
        @(negedge clk_i);
        @(negedge clk_i);
        idModel   = 0;
        doneCount = 0;
        startSeen = 1'b0;
        rst_i     = 1'b0;

        $display("[TB] ID wrap");
        vd = 3;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(i + 1, 1, 1, i, i * 2, i * 3, 1'b1);
        end
        waitIdle();
        checkOutput("wrap_done_count", 64'(doneCount), 64'd17);
        checkOutput("wrap_last_id",    64'(done_id_o), 64'd0);
        checkOutput("wrap_cmd_id",     64'(cmd_id_o),  64'd1);

        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
